bure_stage_mem: RTL and testbench



---
 rtl/bure_stage_mem.sv | 235 +++++++++++++++++++++++
 tb/tb_bure_stage_mem.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bure_stage_mem.sv
// bure_stage_mem: memory-access stage sitting right after execute.
// Accepts one instruction when i_ex_valid && o_ex_ready. Loads and stores go
// out on a req/gnt/rvalid data bus, and every accepted instruction produces
// exactly one registered writeback pulse.
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_ex_*, i_rs2_data,  instruction from execute (address/result, store data,
//   i_funct3, i_is_*,    access width, op kind, destination register)
//   i_rd_*
//   o_ex_ready           high only in IDLE
//   o_dmem_*, i_dmem_*   data-memory bus (word address, byte enables, lane data)
//   o_wb_*               writeback record, one-cycle valid pulse
//   o_exc, o_exc_cause   exception pulse with o_wb_valid (0 ld mis, 1 st mis, 2 width)
//
//   state | meaning
//   IDLE  | ready to accept; non-memory ops and exceptions retire from here
//   REQ   | bus request held until granted
//   WAIT  | load granted, waiting for read data
module bure_stage_mem #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_ex_valid,
  output logic                      o_ex_ready,
  input  logic [DATA_WIDTH-1:0]     i_ex_data,
  input  logic [DATA_WIDTH-1:0]     i_rs2_data,
  input  logic [2:0]                i_funct3,
  input  logic                      i_is_load,
  input  logic                      i_is_store,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                      i_rd_we,
  output logic                      o_dmem_req,
  input  logic                      i_dmem_gnt,
  output logic [ADDR_WIDTH-1:0]     o_dmem_addr,
  output logic                      o_dmem_we,
  output logic [3:0]                o_dmem_be,
  output logic [DATA_WIDTH-1:0]     o_dmem_wdata,
  input  logic                      i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]     i_dmem_rdata,
  output logic                      o_wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] o_wb_rd_addr,
  output logic [DATA_WIDTH-1:0]     o_wb_rd_data,
  output logic                      o_wb_rd_we,
  output logic                      o_exc,
  output logic [1:0]                o_exc_cause
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

  state_e                    state_q, state_d;
  logic                      req_q, req_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      we_q, we_d;
  logic [3:0]                be_q, be_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [1:0]                off_q, off_d;
  logic [2:0]                funct3_q, funct3_d;
  logic                      is_load_q, is_load_d;
  logic                      rd_we_q, rd_we_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_q, wb_rd_addr_d;
  logic [DATA_WIDTH-1:0]     wb_rd_data_q, wb_rd_data_d;
  logic                      wb_rd_we_q, wb_rd_we_d;
  logic                      exc_q, exc_d;
  logic [1:0]                exc_cause_q, exc_cause_d;

  logic [1:0]            off;
  logic                  is_mem;
  logic                  width_ok;
  logic                  misaligned;
  logic [3:0]            be_mask;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_val;

  assign off    = i_ex_data[1:0];
  assign is_mem = i_is_load | i_is_store;

  always_comb begin
    width_ok = 1'b0;
    if (i_is_load)
      width_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                 (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
    else if (i_is_store)
      width_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
  end

  // funct3[1:0] encodes size for every legal width (bit 2 only selects zero-extension).
  assign misaligned = ((i_funct3[1:0] == 2'b01) && off[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (off != 2'b00));

  always_comb begin
    case (i_funct3[1:0])
      2'b00:   begin be_mask = 4'b0001 << off; wdata_rep = {4{i_rs2_data[7:0]}};  end
      2'b01:   begin be_mask = 4'b0011 << off; wdata_rep = {2{i_rs2_data[15:0]}}; end
      default: begin be_mask = 4'b1111;        wdata_rep = i_rs2_data;            end
    endcase
  end

  assign lane = i_dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: load_val = i_dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    off_d        = off_q;
    funct3_d     = funct3_q;
    is_load_d    = is_load_q;
    rd_we_d      = rd_we_q;
    wb_valid_d   = 1'b0;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_rd_data_d = wb_rd_data_q;
    wb_rd_we_d   = 1'b0;
    exc_d        = 1'b0;
    exc_cause_d  = exc_cause_q;

    case (state_q)
      ST_IDLE: begin
        if (i_ex_valid) begin
          wb_rd_addr_d = i_rd_addr;
          off_d        = off;
          funct3_d     = i_funct3;
          is_load_d    = i_is_load;
          rd_we_d      = i_rd_we;
          if (!is_mem) begin
            wb_valid_d   = 1'b1;
            wb_rd_data_d = i_ex_data;
            wb_rd_we_d   = i_rd_we;
          end else if (!width_ok || misaligned) begin
            wb_valid_d   = 1'b1;
            wb_rd_data_d = i_ex_data;
            exc_d        = 1'b1;
            exc_cause_d  = !width_ok ? 2'd2 : (i_is_load ? 2'd0 : 2'd1);
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            addr_d  = {i_ex_data[ADDR_WIDTH-1:2], 2'b00};
            we_d    = i_is_store;
            be_d    = be_mask;
            wdata_d = wdata_rep;
          end
        end
      end
      ST_REQ: begin
        if (i_dmem_gnt) begin
          req_d = 1'b0;
          if (is_load_q) begin
            state_d = ST_WAIT;
          end else begin
            state_d      = ST_IDLE;
            wb_valid_d   = 1'b1;
            wb_rd_data_d = '0;
          end
        end
      end
      ST_WAIT: begin
        if (i_dmem_rvalid) begin
          state_d      = ST_IDLE;
          wb_valid_d   = 1'b1;
          wb_rd_data_d = load_val;
          wb_rd_we_d   = rd_we_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      off_q        <= '0;
      funct3_q     <= '0;
      is_load_q    <= 1'b0;
      rd_we_q      <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_addr_q <= '0;
      wb_rd_data_q <= '0;
      wb_rd_we_q   <= 1'b0;
      exc_q        <= 1'b0;
      exc_cause_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      off_q        <= off_d;
      funct3_q     <= funct3_d;
      is_load_q    <= is_load_d;
      rd_we_q      <= rd_we_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_data_q <= wb_rd_data_d;
      wb_rd_we_q   <= wb_rd_we_d;
      exc_q        <= exc_d;
      exc_cause_q  <= exc_cause_d;
    end
  end

  assign o_ex_ready   = (state_q == ST_IDLE);
  assign o_dmem_req   = req_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_we    = we_q;
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;
  assign o_wb_valid   = wb_valid_q;
  assign o_wb_rd_addr = wb_rd_addr_q;
  assign o_wb_rd_data = wb_rd_data_q;
  assign o_wb_rd_we   = wb_rd_we_q;
  assign o_exc        = exc_q;
  assign o_exc_cause  = exc_cause_q;

endmodule

// File: tb/tb_bure_stage_mem.sv
module tb_bure_stage_mem;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_data = '0;
  logic [31:0] rs2_data = '0;
  logic [2:0]  funct3 = '0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic        rd_we = 1'b0;
  logic        dmem_req;
  logic        dmem_gnt = 1'b0;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        wb_rd_we;
  logic        exc;
  logic [1:0]  exc_cause;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bure_stage_mem dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
    .i_ex_data(ex_data), .i_rs2_data(rs2_data), .i_funct3(funct3),
    .i_is_load(is_load), .i_is_store(is_store),
    .i_rd_addr(rd_addr), .i_rd_we(rd_we),
    .o_dmem_req(dmem_req), .i_dmem_gnt(dmem_gnt), .o_dmem_addr(dmem_addr),
    .o_dmem_we(dmem_we), .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata),
    .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_wb_valid(wb_valid), .o_wb_rd_addr(wb_rd_addr), .o_wb_rd_data(wb_rd_data),
    .o_wb_rd_we(wb_rd_we), .o_exc(exc), .o_exc_cause(exc_cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, legality and expected bus/writeback values
  // derived from plain arithmetic on the op description.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] exd, input logic [31:0] rs2,
                       input logic [4:0] rd, input bit rdwe,
                       input int gnt_dly, input int rv_dly,
                       input logic [31:0] rdata, input bit spur);
    int size, off;
    bit legal, mis;
    logic [31:0] exp_be, exp_wd, exp_ld, raw;
    logic [1:0] cause;
    off  = int'(exd % 4);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    mis   = (off % size) != 0;
    cause = !legal ? 2'd2 : (ld ? 2'd0 : 2'd1);
    exp_be = (size == 4) ? 32'hF : (((32'd1 << size) - 1) << off);
    exp_wd = (size == 1) ? {24'd0, rs2[7:0]} * 32'h01010101 :
             (size == 2) ? {16'd0, rs2[15:0]} * 32'h00010001 : rs2;
    raw = rdata / (32'd1 << (8 * off));
    if (size == 4)      exp_ld = rdata;
    else if (size == 1) exp_ld = (raw % 256) + ((!f3[2] && (raw % 256) >= 128) ? 32'hFFFFFF00 : 0);
    else                exp_ld = (raw % 65536) + ((!f3[2] && (raw % 65536) >= 32768) ? 32'hFFFF0000 : 0);

    @(negedge clk);
    chk("ready_pre", ex_ready, 1);
    chk("wb_pulse_end", wb_valid, 0);
    ex_valid = 1; is_load = ld; is_store = st; funct3 = f3; ex_data = exd;
    rs2_data = rs2; rd_addr = rd; rd_we = rdwe;
    @(negedge clk);
    ex_valid = 0;
    if (!ld && !st) begin
      chk("np_wb_valid", wb_valid, 1);
      chk("np_data", wb_rd_data, exd);
      chk("np_rd", wb_rd_addr, rd);
      chk("np_we", wb_rd_we, rdwe);
      chk("np_exc", exc, 0);
      chk("np_req", dmem_req, 0);
      return;
    end
    if (!legal || mis) begin
      chk("ex_wb_valid", wb_valid, 1);
      chk("ex_exc", exc, 1);
      chk("ex_cause", exc_cause, cause);
      chk("ex_we", wb_rd_we, 0);
      chk("ex_rd", wb_rd_addr, rd);
      chk("ex_req", dmem_req, 0);
      return;
    end
    for (int i = 0; i <= gnt_dly; i++) begin
      chk("req", dmem_req, 1);
      chk("req_addr", dmem_addr, {exd[31:2], 2'b00});
      chk("req_be", dmem_be, exp_be);
      chk("req_we", dmem_we, st);
      if (st) chk("req_wdata", dmem_wdata, exp_wd);
      chk("req_ready", ex_ready, 0);
      chk("req_wb", wb_valid, 0);
      if (i == gnt_dly) begin
        dmem_gnt = 1;
      end else begin
        dmem_rvalid = spur;
        dmem_rdata = ~rdata;
      end
      @(negedge clk);
      dmem_gnt = 0;
      dmem_rvalid = 0;
    end
    chk("gnt_req_drop", dmem_req, 0);
    if (st) begin
      chk("st_wb_valid", wb_valid, 1);
      chk("st_we", wb_rd_we, 0);
      chk("st_exc", exc, 0);
      chk("st_ready", ex_ready, 1);
      return;
    end
    for (int i = 0; i <= rv_dly; i++) begin
      chk("wait_ready", ex_ready, 0);
      chk("wait_wb", wb_valid, 0);
      if (i == rv_dly) begin
        dmem_rvalid = 1;
        dmem_rdata = rdata;
      end
      @(negedge clk);
      dmem_rvalid = 0;
    end
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_data", wb_rd_data, exp_ld);
    chk("ld_we", wb_rd_we, rdwe);
    chk("ld_rd", wb_rd_addr, rd);
    chk("ld_exc", exc, 0);
    chk("ld_ready", ex_ready, 1);
  endtask

  initial begin
    #12;
    chk("rst_ready", ex_ready, 1);
    chk("rst_req", dmem_req, 0);
    chk("rst_wb", wb_valid, 0);
    chk("rst_exc", exc, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wbdata", wb_rd_data, 0);
    chk("rst_cause", exc_cause, 0);
    rstn = 1;

    // back-to-back non-memory ops
    @(negedge clk);
    ex_valid = 1; is_load = 0; is_store = 0; ex_data = 32'h12345678; rd_addr = 5; rd_we = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_wb", wb_valid, 1);
      chk("b2b_data", wb_rd_data, 32'h12345678);
      chk("b2b_rd", wb_rd_addr, 5);
      chk("b2b_ready", ex_ready, 1);
      chk("b2b_req", dmem_req, 0);
    end
    ex_valid = 0;

    // directed cases
    do_op(0, 1, 3'b000, 32'h1003, 32'hAABBCCDD, 7, 1, 3, 0, 0, 0);
    do_op(1, 0, 3'b000, 32'h3003, 0, 1, 1, 0, 0, 32'h80FF7F01, 0);
    do_op(1, 0, 3'b100, 32'h3003, 0, 2, 1, 0, 0, 32'h80FF7F01, 0);
    do_op(1, 0, 3'b001, 32'h3002, 0, 3, 1, 0, 0, 32'h80FF7F01, 0);
    do_op(1, 0, 3'b101, 32'h3000, 0, 4, 1, 0, 0, 32'h80FF7F01, 0);
    do_op(1, 0, 3'b010, 32'h3000, 0, 6, 1, 2, 2, 32'h80FF7F01, 1);
    do_op(1, 0, 3'b010, 32'h2002, 0, 8, 1, 0, 0, 0, 0);
    do_op(0, 1, 3'b001, 32'h2001, 0, 9, 1, 0, 0, 0, 0);
    do_op(1, 0, 3'b011, 32'h2000, 0, 10, 1, 0, 0, 0, 0);

    // held ex_valid across a load: the next op is taken as soon as the load retires
    @(negedge clk);
    ex_valid = 1; is_load = 1; is_store = 0; funct3 = 3'b010; ex_data = 32'h4000; rd_addr = 11; rd_we = 1;
    @(negedge clk);
    is_load = 0; ex_data = 32'h5555AAAA; rd_addr = 12;
    chk("hold_ready_req", ex_ready, 0);
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    chk("hold_ready_wait", ex_ready, 0);
    dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    dmem_rvalid = 0;
    chk("hold_ld_wb", wb_valid, 1);
    chk("hold_ld_data", wb_rd_data, 32'hCAFEF00D);
    chk("hold_ready_wb", ex_ready, 1);
    @(negedge clk);
    ex_valid = 0;
    chk("hold_next_wb", wb_valid, 1);
    chk("hold_next_data", wb_rd_data, 32'h5555AAAA);
    chk("hold_next_rd", wb_rd_addr, 12);

    // reset while requesting
    @(negedge clk);
    ex_valid = 1; is_load = 1; is_store = 0; funct3 = 3'b010; ex_data = 32'h6000; rd_addr = 13;
    @(negedge clk);
    ex_valid = 0;
    chk("rr_req", dmem_req, 1);
    #2 rstn = 0;
    #1;
    chk("rr_req_drop", dmem_req, 0);
    chk("rr_ready", ex_ready, 1);
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_no_wb", wb_valid, 0);
      chk("rr_idle", ex_ready, 1);
      chk("rr_no_req", dmem_req, 0);
    end

    // random ops
    for (int n = 0; n < 80; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_op(kind == 1, kind == 2, 3'($urandom_range(0, 7)), $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
